// File: rtl/data_mem_responder.sv
// Load/store responder: one request per handshake, word-wide synchronous RAM, lane select and extension.
// Optional feature macro LS_MISALIGN_TRAP_EN: flag misaligned/reserved accesses instead of forcing alignment.
module data_mem_responder #(
  parameter int ADDR_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic              store_q, store_d;
  logic              signed_q, signed_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] word_idx;
  logic [1:0]        eff_size;
  logic [1:0]        lane_off;
  logic [3:0]        byte_en;
  logic              misalign;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;
  logic              accept;

  assign accept = req_valid && (state_q == S_IDLE);

  // Only the address bits that select a RAM word or a lane are kept; higher bits wrap.
  assign word_idx = addr_q[ADDR_W+1:2];

`ifdef LS_MISALIGN_TRAP_EN
  assign eff_size = size_q;
  assign misalign = (size_q == 2'b11) ||
                    ((size_q == 2'b01) && addr_q[0]) ||
                    ((size_q == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  assign eff_size = (size_q == 2'b11) ? 2'b10 : size_q;
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_off = 2'b00;
    byte_en  = 4'b1111;
    unique case (eff_size)
      2'b00: begin
        lane_off = addr_q[1:0];
        byte_en  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane_off = {addr_q[1], 1'b0};
        byte_en  = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        lane_off = 2'b00;
        byte_en  = 4'b1111;
      end
    endcase
  end

  assign wr_data = req_wdata_shift(wdata_q, lane_off);
  assign rd_word = mem[word_idx];
  assign rd_byte = rd_word[{lane_off, 3'b000} +: 8];
  assign rd_half = rd_word[{lane_off[1], 4'b0000} +: 16];

  function automatic logic [31:0] req_wdata_shift(input logic [31:0] d, input logic [1:0] off);
    return d << {off, 3'b000};
  endfunction

  always_comb begin
    load_ext = rd_word;
    unique case (eff_size)
      2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = rd_word;
    endcase
  end

  // NOTE: the RAM array is deliberately left out of reset; only control and response state is reset.
  always_ff @(posedge clk) begin
    if ((state_q == S_ACCESS) && store_q && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    signed_d = signed_q;
    size_d   = size_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_ACCESS;
          store_d  = req_store;
          signed_d = req_signed;
          size_d   = req_size;
          addr_d   = req_addr[ADDR_W+1:0];
          wdata_d  = req_wdata;
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        rdata_d = (store_q || misalign) ? 32'h0 : load_ext;
        err_d   = misalign;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      store_q  <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      signed_q <= signed_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder; expectations follow LS_MISALIGN_TRAP_EN when it is defined.
module tb_data_mem_responder;

  localparam int ADDR_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_size  (req_size),
    .req_signed(req_signed),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one request with rsp_ready high; lat counts negedges after the accept edge until rsp_valid (-1 on timeout).
  task automatic xfer(input logic st, input logic [1:0] sz, input logic sg,
                      input logic [31:0] ad, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg;
    req_addr = ad; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      req_valid = 1'b0; rd = 32'h0; er = 1'b0; lat = -1;
      return;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 10);
    if (!rsp_valid) lat = -1;
    rd = rsp_rdata; er = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, busy} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/vld/err/busy=%b want 1000", {req_ready, rsp_valid, rsp_err, busy});
    end
    n_checks++;
    if (rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00000000", rsp_rdata);
    end
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'h0 || er !== 1'b0) begin
      n_fail++; $display("FAIL store_word: got lat=%0d rdata=%h err=%b want lat=2 rdata=0 err=0", lat, rd, er);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_3cyc: got req_ready=%b want 1", req_ready);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++; $display("FAIL load_word: got lat=%0d rdata=%h err=%b want lat=2 rdata=deadbeef err=0", lat, rd, er);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345680, rd, er, lat);
    xfer(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin
      n_fail++; $display("FAIL byte_signed: got %h err=%b want ffffff80 err=0", rd, er);
    end
    xfer(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00000080) begin
      n_fail++; $display("FAIL byte_unsigned: got %h want 00000080", rd);
    end
    xfer(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFFFBE) begin
      n_fail++; $display("FAIL byte_lane1: got %h want ffffffbe", rd);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h80ADBEEF) begin
      n_fail++; $display("FAIL byte_word_merge: got %h want 80adbeef", rd);
    end
  endtask

  task automatic test_reset_mid_resp();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_addr = 32'h10;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h80ADBEEF) begin
      n_fail++; $display("FAIL pre_reset_resp: got vld=%b rdata=%h want 1 80adbeef", rsp_valid, rsp_rdata);
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, req_ready, busy} !== 3'b010 || rsp_rdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: got vld/rdy/busy=%b rdata=%h want 010 00000000", {rsp_valid, req_ready, busy}, rsp_rdata);
    end
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL no_replay: got vld=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_abort_store();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'h11111111, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'b10; req_addr = 32'h20; req_wdata = 32'h22222222;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2 rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle: got busy=%b want 0", busy);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h11111111) begin
      n_fail++; $display("FAIL abort_ram: got %h want 11111111", rd);
    end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFFABCD, rd, er, lat);
    xfer(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFFABCD) begin
      n_fail++; $display("FAIL half_signed_hi: got %h want ffffabcd", rd);
    end
    xfer(1'b0, 2'b01, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'h00001111) begin
      n_fail++; $display("FAIL half_unsigned_lo: got %h want 00001111", rd);
    end
    xfer(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hFFFF80AD) begin
      n_fail++; $display("FAIL half_signed_80ad: got %h want ffff80ad", rd);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hABCD1111) begin
      n_fail++; $display("FAIL half_word_merge: got %h want abcd1111", rd);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h10;
    @(posedge clk); #1;
    req_size = 2'b00;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h80ADBEEF) begin
        n_fail++;
        $display("FAIL hold_resp[%0d]: got vld=%b rdy=%b rdata=%h want 1 0 80adbeef", i, rsp_valid, req_ready, rsp_rdata);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
    @(posedge clk); #1 req_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL second_accept: got busy=%b want 1", busy);
    end
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h000000EF) begin
      n_fail++; $display("FAIL second_resp: got vld=%b rdata=%h want 1 000000ef", rsp_valid, rsp_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] exp_word; logic exp_err; logic [31:0] exp_r11;
`ifdef LS_MISALIGN_TRAP_EN
    exp_word = 32'h80ADBEEF; exp_err = 1'b1; exp_r11 = 32'h0;
`else
    exp_word = 32'h80AD1234; exp_err = 1'b0; exp_r11 = 32'h80AD1234;
`endif
    xfer(1'b1, 2'b01, 1'b0, 32'h11, 32'h00001234, rd, er, lat);
    n_checks++;
    if (er !== exp_err || rd !== 32'h0 || lat !== 2) begin
      n_fail++; $display("FAIL misalign_store: got err=%b rdata=%h lat=%0d want err=%b rdata=0 lat=2", er, rd, lat, exp_err);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_word || er !== 1'b0) begin
      n_fail++; $display("FAIL misalign_word: got %h err=%b want %h err=0", rd, er, exp_word);
    end
    xfer(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_r11 || er !== exp_err) begin
      n_fail++; $display("FAIL size_reserved: got %h err=%b want %h err=%b", rd, er, exp_r11, exp_err);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== exp_r11 || er !== exp_err) begin
      n_fail++; $display("FAIL word_misaligned_load: got %h err=%b want %h err=%b", rd, er, exp_r11, exp_err);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    logic [31:0] wrap_addr;
    wrap_addr = (32'd4 << ADDR_W) + 32'h8;
    xfer(1'b1, 2'b10, 1'b0, wrap_addr, 32'hCAFEF00D, rd, er, lat);
    xfer(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap_low: got %h want cafef00d", rd);
    end
    xfer(1'b0, 2'b10, 1'b0, 32'hFFFC0008, 32'h0, rd, er, lat);
    n_checks++;
    if (rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL wrap_high: got %h want cafef00d", rd);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_reset_mid_resp();
    test_abort_store();
    test_half();
    test_backpressure();
    test_misalign();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
